mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, memory word width; ADDR_WIDTH, default 8, memory address width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  controller accepts request; transfer when req_valid & req_ready at a rising edge.
REQ-006 req_rw  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_WIDTH  start address.
REQ-008 req_wdata  input  DATA_WIDTH  write (fill) data.
REQ-009 req_len  input  4  burst beats minus one (0 -> 1 beat, 15 -> 16 beats).
REQ-010 rsp_valid  output  1  response word available.
REQ-011 rsp_ready  input  1  host takes response; transfer when rsp_valid & rsp_ready at a rising edge.
REQ-012 rsp_data  output  DATA_WIDTH  read word, or 0 for write completion.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 mem_din, mem_addr, mem_rw, mem_valid  output  DATA_WIDTH/ADDR_WIDTH/1/1  memory port (rw 1 = write); memory samples them on the rising edge.
REQ-015 mem_dout  input  DATA_WIDTH  memory read data, valid in the cycle after the sampling edge of a read.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, RESP; req_ready = (state==IDLE) & ~reset.
REQ-017 Acceptance edge E0 SHALL latch rw, addr, wdata, beat count and go to ISSUE.
REQ-018 ISSUE SHALL drive mem_valid=1 for exactly one cycle per beat with mem_addr = current address, mem_rw = latched rw, mem_din = latched wdata (0 for reads).
REQ-019 Write beat: ISSUE -> ISSUE (next beat, back-to-back, mem_valid stays high) or, after last beat, -> RESP with rsp_data=0; single write: rsp_valid high after E1.
REQ-020 Read beat: ISSUE -> WAIT; WAIT captures mem_dout into rsp_data at its end edge -> RESP; single read: rsp_valid high after E2.
REQ-021 RESP SHALL hold rsp_valid and rsp_data stable until rsp_ready; on transfer go to ISSUE (read beats remaining) or IDLE.
REQ-022 Read burst SHALL emit one response per beat; write burst SHALL emit one completion response only.
REQ-023 Address SHALL increment by 1 per beat modulo 2^ADDR_WIDTH (0xFF -> 0x00 with defaults).
REQ-024 mem_valid SHALL be 0 in IDLE, WAIT, RESP; no memory access while a response is stalled.
REQ-025 rsp_ready high while rsp_valid low SHALL have no effect; req_valid outside IDLE SHALL be ignored.

Reset
REQ-026 While reset is high: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, mem_valid=0, mem_rw=0, mem_addr=0, mem_din=0, immediately (asynchronously).
REQ-027 Reset mid-burst SHALL abandon the burst; no further mem_valid or rsp_valid until a new request after reset release.

Configuration
REQ-028 Macro MEM_ACCESS_CTRL_BURST_EN defined: req_len honoured (1..16 beats).
REQ-029 Macro undefined: req_len ignored, every request is exactly one beat; all other behaviour unchanged.

Verification
REQ-030 Write addr=0x04 data=0x7 -> one mem_valid cycle with mem_rw=1, mem_addr=0x04, mem_din=0x7; rsp_valid after E1 with rsp_data=0.
REQ-031 Read addr=0x04 after REQ-030, rsp_ready=1 -> mem_rw=0 access, rsp_valid after E2, rsp_data=0x7, back to IDLE.
REQ-032 (BURST_EN) read addr=0xFE req_len=3, rsp_ready toggled 1/0 -> mem_addr 0xFE,0xFF,0x00,0x01; four responses in order; no mem_valid while rsp_valid&~rsp_ready.
REQ-033 (BURST_EN) write fill addr=0x10 req_len=2 data=0x10 -> three consecutive mem_valid cycles at 0x10..0x12, one completion response.
REQ-034 Reset asserted during WAIT of a burst read -> all outputs 0 at once, no rsp_valid; next single read after release completes normally.
REQ-035 Macro undefined, req_len=5 read -> exactly one memory access and one response.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Host-to-SRAM access controller: single or burst read/write with one response per read beat.
// Burst length support is compiled in with MEM_ACCESS_CTRL_BURST_EN; without it every request is one beat.
//
// state | meaning
// IDLE  | waiting for a host request, req_ready high
// ISSUE | memory strobe active for the current beat
// WAIT  | read data returning from memory, captured at the end of this cycle
// RESP  | response held for the host until rsp_ready
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rw,
    output logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] beats_left;
    logic [3:0] len_eff;

`ifdef MEM_ACCESS_CTRL_BURST_EN
    assign len_eff = req_len;
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign len_eff    = 4'd0;
`endif

    assign req_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE);

    // mem_rw doubles as the latched transfer direction for the whole burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            mem_valid  <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= ISSUE;
                        mem_valid  <= 1'b1;
                        mem_rw     <= req_rw;
                        mem_addr   <= req_addr;
                        mem_din    <= req_rw ? req_wdata : '0;
                        beats_left <= len_eff;
                    end
                end
                ISSUE: begin
                    if (mem_rw) begin
                        if (beats_left != 4'd0) begin
                            beats_left <= beats_left - 4'd1;
                            mem_addr   <= mem_addr + ADDR_ONE;
                        end else begin
                            mem_valid <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end
                    end else begin
                        mem_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_data  <= mem_dout;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!mem_rw && beats_left != 4'd0) begin
                            beats_left <= beats_left - 4'd1;
                            mem_addr   <= mem_addr + ADDR_ONE;
                            mem_valid  <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural SRAM on the memory port.
// Burst sequences are exercised when MEM_ACCESS_CTRL_BURST_EN is defined, the single-beat fallback otherwise.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic [31:0] mem_din;
    logic [7:0]  mem_addr;
    logic        mem_rw;
    logic        mem_valid;
    logic [31:0] mem_dout = '0;

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .mem_din(mem_din), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_valid(mem_valid), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_valid) begin
            if (mem_rw) mem[mem_addr] <= mem_din;
            else        mem_dout <= mem[mem_addr];
        end
    end

    // Access log and response-stall watcher.
    logic [7:0]  acc_addr_q[$];
    logic        acc_rw_q[$];
    logic [31:0] acc_din_q[$];
    int          acc_cyc_q[$];
    logic [31:0] rsp_q[$];
    int          cyc_cnt = 0;
    int          stall_err = 0;
    bit          stall_pend = 0;
    logic [31:0] stall_data = '0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_valid) begin
            acc_addr_q.push_back(mem_addr);
            acc_rw_q.push_back(mem_rw);
            acc_din_q.push_back(mem_din);
            acc_cyc_q.push_back(cyc_cnt);
        end
        if (reset) begin
            stall_pend = 0;
        end else begin
            if (stall_pend && (!rsp_valid || rsp_data !== stall_data)) stall_err++;
            if (mem_valid && rsp_valid && !rsp_ready) stall_err++;
            stall_pend = rsp_valid && !rsp_ready;
            stall_data = rsp_data;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        acc_addr_q.delete();
        acc_rw_q.delete();
        acc_din_q.delete();
        acc_cyc_q.delete();
        rsp_q.delete();
    endtask

    // One host transaction: lat = clock edges after acceptance until rsp_valid is seen.
    task automatic run_txn(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] len, input int n_rsp, input bit toggle,
                           input bit hold, output int lat, output bit timeout);
        int  cyc;
        int  got;
        bit  done;
        @(negedge clk);
        clear_logs();
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        req_len   = len;
        rsp_ready = toggle ? 1'b1 : 1'b1;
        @(posedge clk);
        lat = -1; timeout = 0; cyc = 0; got = 0; done = 0;
        while (!done && !timeout) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (toggle) rsp_ready = ~rsp_ready;
            if (rsp_valid && lat < 0) lat = cyc;
            if (rsp_valid && rsp_ready) begin
                rsp_q.push_back(rsp_data);
                got++;
                if (got == n_rsp) begin
                    done      = 1;
                    req_valid = 1'b0;
                end
            end
            cyc++;
            if (cyc > 150) timeout = 1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int lat;
        bit to;
        int quiet;

        foreach (mem[i]) mem[i] = '0;

        vecs[0] = '{1'b1, 8'h04, 32'h0000_0007, 32'h0, 1};
        vecs[1] = '{1'b0, 8'h04, 32'hFFFF_FFFF, 32'h0000_0007, 2};
        vecs[2] = '{1'b1, 8'hFF, 32'hDEAD_BEEF, 32'h0, 1};
        vecs[3] = '{1'b0, 8'hFF, 32'h0, 32'hDEAD_BEEF, 2};
        vecs[4] = '{1'b1, 8'h00, 32'h1234_5678, 32'h0, 1};
        vecs[5] = '{1'b0, 8'h00, 32'h0, 32'h1234_5678, 2};
        vecs[6] = '{1'b0, 8'h04, 32'h0, 32'h0000_0007, 2};
        vecs[7] = '{1'b1, 8'h80, 32'hA5A5_A5A5, 32'h0, 1};
        vecs[8] = '{1'b0, 8'h80, 32'h0, 32'hA5A5_A5A5, 2};

        #1 reset = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 chk("idle_req_ready", req_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 4'd0, 1, 0, 0, lat, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_accesses", i), acc_addr_q.size(), 1);
            chk($sformatf("v%0d_mem_addr", i), acc_addr_q[0], vecs[i].addr);
            chk($sformatf("v%0d_mem_rw", i), acc_rw_q[0], vecs[i].rw);
            chk($sformatf("v%0d_mem_din", i), acc_din_q[0], vecs[i].rw ? vecs[i].wdata : 32'h0);
            chk($sformatf("v%0d_rsp_data", i), rsp_q[0], vecs[i].exp_data);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
        end

        // req_valid held high through a read must not start a second access.
        run_txn(1'b0, 8'h04, 32'h0, 4'd0, 1, 0, 1, lat, to);
        idle_cycles(4);
        chk("hold_timeout", to, 0);
        chk("hold_accesses", acc_addr_q.size(), 1);
        chk("hold_rsp_data", rsp_q[0], 32'h7);

`ifdef MEM_ACCESS_CTRL_BURST_EN
        run_txn(1'b1, 8'hFE, 32'hAAAA_0001, 4'd0, 1, 0, 0, lat, to);
        run_txn(1'b1, 8'hFF, 32'hAAAA_0002, 4'd0, 1, 0, 0, lat, to);
        run_txn(1'b1, 8'h00, 32'hAAAA_0003, 4'd0, 1, 0, 0, lat, to);
        run_txn(1'b1, 8'h01, 32'hAAAA_0004, 4'd0, 1, 0, 0, lat, to);
        run_txn(1'b0, 8'hFE, 32'h0, 4'd3, 4, 1, 0, lat, to);
        chk("rburst_timeout", to, 0);
        chk("rburst_accesses", acc_addr_q.size(), 4);
        chk("rburst_addr0", acc_addr_q[0], 8'hFE);
        chk("rburst_addr1", acc_addr_q[1], 8'hFF);
        chk("rburst_addr2", acc_addr_q[2], 8'h00);
        chk("rburst_addr3", acc_addr_q[3], 8'h01);
        chk("rburst_rw", acc_rw_q[3], 0);
        chk("rburst_rsps", rsp_q.size(), 4);
        chk("rburst_d0", rsp_q[0], 32'hAAAA_0001);
        chk("rburst_d1", rsp_q[1], 32'hAAAA_0002);
        chk("rburst_d2", rsp_q[2], 32'hAAAA_0003);
        chk("rburst_d3", rsp_q[3], 32'hAAAA_0004);

        run_txn(1'b1, 8'h10, 32'h0000_0010, 4'd2, 1, 0, 0, lat, to);
        idle_cycles(3);
        chk("wburst_timeout", to, 0);
        chk("wburst_accesses", acc_addr_q.size(), 3);
        chk("wburst_addr0", acc_addr_q[0], 8'h10);
        chk("wburst_addr1", acc_addr_q[1], 8'h11);
        chk("wburst_addr2", acc_addr_q[2], 8'h12);
        chk("wburst_din2", acc_din_q[2], 32'h10);
        chk("wburst_back2back", acc_cyc_q[2] - acc_cyc_q[0], 2);
        chk("wburst_rsps", rsp_q.size(), 1);
        chk("wburst_rsp_data", rsp_q[0], 32'h0);
        chk("wburst_latency", lat, 3);
`else
        run_txn(1'b0, 8'h04, 32'h0, 4'd5, 1, 0, 0, lat, to);
        idle_cycles(5);
        chk("len5_timeout", to, 0);
        chk("len5_accesses", acc_addr_q.size(), 1);
        chk("len5_rsps", rsp_q.size(), 1);
        chk("len5_rsp_data", rsp_q[0], 32'h7);
        chk("len5_busy", busy, 0);
`endif

        // Reset while a read sits in WAIT.
        @(negedge clk);
        clear_logs();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h80; req_len = 4'd3; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstw_issue_mem_valid", mem_valid, 1);
        @(negedge clk);
        chk("rstw_wait_busy", busy, 1);
        chk("rstw_wait_mem_valid", mem_valid, 0);
        #2 reset = 1'b1;
        #1;
        chk("rstw_req_ready", req_ready, 0);
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_rsp_data", rsp_data, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_valid", mem_valid, 0);
        chk("rstw_mem_rw", mem_rw, 0);
        chk("rstw_mem_addr", mem_addr, 0);
        chk("rstw_mem_din", mem_din, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_valid || rsp_valid) quiet++;
        end
        chk("rstw_quiet_after", quiet, 0);
        run_txn(1'b0, 8'h80, 32'h0, 4'd0, 1, 0, 0, lat, to);
        chk("rstw_next_timeout", to, 0);
        chk("rstw_next_latency", lat, 2);
        chk("rstw_next_data", rsp_q[0], 32'hA5A5_A5A5);

        chk("stall_violations", stall_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
